// File: rtl/axi_store_issue_limiter.sv
// rtl/axi_store_issue_limiter.sv - splits single-beat stores into AW/W, caps in-flight stores, drain handshake
// Define CVA6_STORE_LIMIT_ERR_CNT_EN to add the saturating B-error counter output err_cnt_o.
module axi_store_issue_limiter #(
  parameter int unsigned MaxOutstanding = 7,
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned IdWidth        = 4,
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic [DataWidth-1:0]   req_data_i,
  input  logic [DataWidth/8-1:0] req_be_i,
  input  logic [IdWidth-1:0]     req_id_i,
  output logic                   aw_valid_o,
  input  logic                   aw_ready_i,
  output logic [AddrWidth-1:0]   aw_addr_o,
  output logic [IdWidth-1:0]     aw_id_o,
  output logic                   w_valid_o,
  input  logic                   w_ready_i,
  output logic [DataWidth-1:0]   w_data_o,
  output logic [DataWidth/8-1:0] w_strb_o,
  output logic                   w_last_o,
  input  logic                   b_valid_i,
  output logic                   b_ready_o,
  input  logic [1:0]             b_resp_i,
  input  logic [IdWidth-1:0]     b_id_i,
  output logic                   rsp_valid_o,
  output logic [IdWidth-1:0]     rsp_id_o,
  output logic                   rsp_err_o,
  input  logic                   flush_i,
  output logic                   flush_ack_o,
  output logic                   no_st_pending_o,
`ifdef CVA6_STORE_LIMIT_ERR_CNT_EN
  output logic [7:0]             err_cnt_o,
`endif
  output logic [CntWidth-1:0]    outstanding_cnt_o
);

  typedef enum logic [1:0] {Idle, Drain, Ack} state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [DataWidth-1:0]   data_q, data_d;
  logic [DataWidth/8-1:0] be_q, be_d;
  logic [IdWidth-1:0]     id_q, id_d;
  logic                   aw_pend_q, aw_pend_d;
  logic                   w_pend_q, w_pend_d;
  logic [CntWidth-1:0]    cnt_q, cnt_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [IdWidth-1:0]     rsp_id_q, rsp_id_d;
  logic                   rsp_err_q, rsp_err_d;

  logic hold_empty, drained, accept, aw_fire, w_fire, b_ok;
  logic unused_resp;

  assign hold_empty  = !aw_pend_q && !w_pend_q;
  assign drained     = hold_empty && (cnt_q == '0);
  assign accept      = req_valid_i && req_ready_o;
  assign aw_fire     = aw_pend_q && aw_ready_i;
  assign w_fire      = w_pend_q && w_ready_i;
  // b_ready_o is tied high, so b_valid_i alone is a handshake; one at cnt 0 is a violation and dropped
  assign b_ok        = b_valid_i && (cnt_q != '0);
  assign unused_resp = b_resp_i[0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= Idle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      Idle:    if (flush_i) state_d = Drain;
      Drain:   if (drained) state_d = Ack;
      Ack:     state_d = Idle;
      default: state_d = Idle;
    endcase
  end

  always_comb begin
    req_ready_o = rst_ni && hold_empty && (cnt_q < CntWidth'(MaxOutstanding)) && (state_q == Idle);
    flush_ack_o = (state_q == Ack);
  end

  always_comb begin
    addr_d    = addr_q;
    data_d    = data_q;
    be_d      = be_q;
    id_d      = id_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    if (accept) begin
      addr_d    = req_addr_i;
      data_d    = req_data_i;
      be_d      = req_be_i;
      id_d      = req_id_i;
      aw_pend_d = 1'b1;
      w_pend_d  = 1'b1;
    end else begin
      if (aw_fire) aw_pend_d = 1'b0;
      if (w_fire)  w_pend_d  = 1'b0;
    end

    cnt_d = cnt_q;
    if (accept && !b_ok)      cnt_d = cnt_q + CntWidth'(1);
    else if (!accept && b_ok) cnt_d = cnt_q - CntWidth'(1);

    rsp_valid_d = b_ok;
    rsp_id_d    = b_ok ? b_id_i : rsp_id_q;
    rsp_err_d   = b_ok ? b_resp_i[1] : rsp_err_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q      <= '0;
      data_q      <= '0;
      be_q        <= '0;
      id_q        <= '0;
      aw_pend_q   <= 1'b0;
      w_pend_q    <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      data_q      <= data_d;
      be_q        <= be_d;
      id_q        <= id_d;
      aw_pend_q   <= aw_pend_d;
      w_pend_q    <= w_pend_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef CVA6_STORE_LIMIT_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (b_valid_i && (b_resp_i[1] || (cnt_q == '0)) && (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_cnt_q <= 8'd0;
    else         err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;
`endif

  assign aw_valid_o        = aw_pend_q;
  assign aw_addr_o         = addr_q;
  assign aw_id_o           = id_q;
  assign w_valid_o         = w_pend_q;
  assign w_data_o          = data_q;
  assign w_strb_o          = be_q;
  assign w_last_o          = 1'b1;
  assign b_ready_o         = 1'b1;
  assign rsp_valid_o       = rsp_valid_q;
  assign rsp_id_o          = rsp_id_q;
  assign rsp_err_o         = rsp_err_q;
  assign no_st_pending_o   = drained;
  assign outstanding_cnt_o = cnt_q;

endmodule

// File: tb/tb_axi_store_issue_limiter.sv
// tb/tb_axi_store_issue_limiter.sv - directed bench with queue-based reference model for axi_store_issue_limiter
// Checks err_cnt_o as well when CVA6_STORE_LIMIT_ERR_CNT_EN is defined.
`timescale 1ns/1ps
module tb_axi_store_issue_limiter;

  localparam int MaxOut = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [63:0] req_addr = '0, req_data = '0;
  logic [7:0]  req_be = '0;
  logic [3:0]  req_id = '0;
  logic        aw_valid, aw_ready = 1'b1;
  logic [63:0] aw_addr;
  logic [3:0]  aw_id;
  logic        w_valid, w_ready = 1'b1;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        w_last;
  logic        b_valid = 1'b0, b_ready;
  logic [1:0]  b_resp = 2'b00;
  logic [3:0]  b_id = '0;
  logic        rsp_valid, rsp_err;
  logic [3:0]  rsp_id;
  logic        flush = 1'b0, flush_ack, no_st_pending;
  logic [2:0]  cnt;
`ifdef CVA6_STORE_LIMIT_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  always #5 clk = ~clk;

  axi_store_issue_limiter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_data_i(req_data), .req_be_i(req_be), .req_id_i(req_id),
    .aw_valid_o(aw_valid), .aw_ready_i(aw_ready), .aw_addr_o(aw_addr), .aw_id_o(aw_id),
    .w_valid_o(w_valid), .w_ready_i(w_ready), .w_data_o(w_data), .w_strb_o(w_strb), .w_last_o(w_last),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_resp_i(b_resp), .b_id_i(b_id),
    .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_err_o(rsp_err),
    .flush_i(flush), .flush_ack_o(flush_ack), .no_st_pending_o(no_st_pending),
`ifdef CVA6_STORE_LIMIT_ERR_CNT_EN
    .err_cnt_o(err_cnt),
`endif
    .outstanding_cnt_o(cnt)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: pending channel beats as queues, stores in flight as a plain count.
  typedef struct { logic [63:0] addr; logic [3:0] id; } aw_t;
  typedef struct { logic [63:0] data; logic [7:0] strb; } w_t;
  aw_t m_aw[$];
  w_t  m_w[$];
  int  m_inflight = 0;
  int  m_phase = 0;          // 0 open, 1 waiting for drain, 2 acknowledging
  bit  m_rv = 0;
  logic [3:0] m_rid = '0;
  logic m_rerr = 1'b0;
  int  m_errs = 0;
  bit  e_ready, e_aw, e_w, acc, awhs, whs, bok, empty_now;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_aw_valid", aw_valid, 0);
      chk("rst_w_valid", w_valid, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_flush_ack", flush_ack, 0);
      chk("rst_no_st_pending", no_st_pending, 1);
      chk("rst_cnt", cnt, 0);
      chk("rst_w_last", w_last, 1);
      chk("rst_b_ready", b_ready, 1);
      m_aw.delete(); m_w.delete();
      m_inflight = 0; m_phase = 0; m_rv = 0; m_errs = 0;
    end else begin
      empty_now = (m_aw.size() == 0) && (m_w.size() == 0);
      e_ready = empty_now && (m_inflight < MaxOut) && (m_phase == 0);
      e_aw = m_aw.size() != 0;
      e_w  = m_w.size() != 0;
      chk("m_req_ready", req_ready, e_ready);
      chk("m_aw_valid", aw_valid, e_aw);
      chk("m_w_valid", w_valid, e_w);
      if (e_aw) begin
        chk("m_aw_addr", aw_addr, m_aw[0].addr);
        chk("m_aw_id", aw_id, m_aw[0].id);
      end
      if (e_w) begin
        chk("m_w_data", w_data, m_w[0].data);
        chk("m_w_strb", w_strb, m_w[0].strb);
      end
      chk("m_w_last", w_last, 1);
      chk("m_b_ready", b_ready, 1);
      chk("m_rsp_valid", rsp_valid, m_rv);
      if (m_rv) begin
        chk("m_rsp_id", rsp_id, m_rid);
        chk("m_rsp_err", rsp_err, m_rerr);
      end
      chk("m_flush_ack", flush_ack, m_phase == 2);
      chk("m_no_st_pending", no_st_pending, empty_now && m_inflight == 0);
      chk("m_cnt", cnt, m_inflight);
`ifdef CVA6_STORE_LIMIT_ERR_CNT_EN
      chk("m_err_cnt", err_cnt, m_errs);
`endif
      acc  = req_valid && e_ready;
      awhs = e_aw && aw_ready;
      whs  = e_w && w_ready;
      bok  = b_valid && (m_inflight > 0);
      if (b_valid && (b_resp[1] || m_inflight == 0) && m_errs < 255) m_errs++;
      m_rv = bok;
      if (bok) begin m_rid = b_id; m_rerr = b_resp[1]; end
      case (m_phase)
        0: if (flush) m_phase = 1;
        1: if (m_inflight == 0 && empty_now) m_phase = 2;
        default: m_phase = 0;
      endcase
      if (awhs) void'(m_aw.pop_front());
      if (whs)  void'(m_w.pop_front());
      if (acc) begin
        m_aw.push_back('{addr: req_addr, id: req_id});
        m_w.push_back('{data: req_data, strb: req_be});
      end
      m_inflight = m_inflight + (acc ? 1 : 0) - (bok ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  // Presents one store and returns just after the edge that accepted it.
  task automatic send(input logic [63:0] a, input logic [3:0] id);
    int waited = 0;
    req_valid = 1'b1; req_addr = a; req_data = {a[31:0], ~a[31:0]};
    req_be = 8'hA5 ^ {4'h0, id}; req_id = id;
    #1;
    while (!req_ready && waited < 50) begin tick(); #1; waited++; end
    chk("send_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
  endtask

  int acks;

  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("lit_ready_after_reset", req_ready, 1);
    chk("lit_cnt_after_reset", cnt, 0);

    // single store, B two cycles after accept
    send(64'h1000, 4'h1);
    chk("t1_aw_valid", aw_valid, 1);
    chk("t1_w_valid", w_valid, 1);
    chk("t1_cnt", cnt, 1);
    chk("t1_aw_addr", aw_addr, 64'h1000);
    tick();
    chk("t1_aw_done", aw_valid, 0);
    b_valid = 1'b1; b_id = 4'h1; b_resp = 2'b00;
    tick();
    b_valid = 1'b0;
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_err", rsp_err, 0);
    chk("t1_rsp_id", rsp_id, 4'h1);
    chk("t1_cnt_back", cnt, 0);
    tick();
    chk("t1_rsp_pulse", rsp_valid, 0);

    // W completes 3 cycles before AW
    aw_ready = 1'b0;
    send(64'h2000, 4'h2);
    tick();
    chk("t2_w_done", w_valid, 0);
    chk("t2_aw_held", aw_valid, 1);
    chk("t2_ready_low", req_ready, 0);
    tick();
    chk("t2_aw_held2", aw_valid, 1);
    chk("t2_aw_addr_stable", aw_addr, 64'h2000);
    tick();
    aw_ready = 1'b1;
    tick();
    #1;
    chk("t2_aw_done", aw_valid, 0);
    chk("t2_ready_back", req_ready, 1);
    b_valid = 1'b1; b_id = 4'h2;
    tick();
    b_valid = 1'b0;
    chk("t2_rsp_id", rsp_id, 4'h2);

    // fill to the cap with B held off
    for (int i = 0; i < 7; i++) send(64'h3000 + 64'(i * 8), 4'(i));
    tick();
    chk("t3_cnt_full", cnt, 7);
    req_valid = 1'b1; req_id = 4'h7; req_addr = 64'h3100;
    #1;
    chk("t3_ready_full", req_ready, 0);
    tick();
    chk("t3_ready_full2", req_ready, 0);
    b_valid = 1'b1; b_id = 4'h0;
    tick();
    b_valid = 1'b0;
    #1;
    chk("t3_ready_after_b", req_ready, 1);
    chk("t3_cnt_6", cnt, 6);
    tick();
    req_valid = 1'b0;
    chk("t3_cnt_refill", cnt, 7);
    tick();
    b_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      b_id = 4'(i);
      tick();
      chk("t3_b2b_valid", rsp_valid, 1);
      chk("t3_b2b_id", rsp_id, 4'(i));
    end
    b_valid = 1'b0;
    chk("t3_cnt_3", cnt, 3);

    // accept and B in the same cycle
    req_valid = 1'b1; req_id = 4'h8; req_addr = 64'h4000;
    b_valid = 1'b1; b_id = 4'h5;
    tick();
    req_valid = 1'b0; b_valid = 1'b0;
    chk("t4_cnt_same", cnt, 3);
    tick();

    // error response, then spurious B at cnt 0
    b_valid = 1'b1; b_resp = 2'b10; b_id = 4'h9;
    tick();
    chk("t6_rsp_err", rsp_err, 1);
    chk("t6_rsp_id", rsp_id, 4'h9);
    b_resp = 2'b00; b_id = 4'hA;
    tick();
    chk("t6_rsp_ok", rsp_err, 0);
    b_id = 4'hB;
    tick();
    chk("t6_cnt_zero", cnt, 0);
    b_id = 4'hC;
    tick();
    b_valid = 1'b0;
    chk("t6_spurious_no_rsp", rsp_valid, 0);
    chk("t6_spurious_cnt", cnt, 0);
`ifdef CVA6_STORE_LIMIT_ERR_CNT_EN
    chk("t6_err_cnt", err_cnt, 2);
`endif

    // flush with nothing pending: ack two cycles after flush_i
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t7_ack_early", flush_ack, 0);
    chk("t7_no_accept", req_ready, 0);
    tick();
    chk("t7_ack", flush_ack, 1);
    tick();
    chk("t7_ack_pulse", flush_ack, 0);
    chk("t7_ready_back", req_ready, 1);

    // flush with two stores out, B at +4 and +6
    send(64'h5000, 4'h1);
    send(64'h5008, 4'h2);
    tick();
    chk("t5_cnt_2", cnt, 2);
    acks = 0;
    for (int k = 0; k <= 10; k++) begin
      flush = (k < 8);
      req_valid = (k >= 1 && k <= 7);
      req_id = 4'hD;
      b_valid = (k == 4 || k == 6);
      b_id = (k == 4) ? 4'h1 : 4'h2;
      #1;
      if (flush_ack) begin
        acks++;
        chk("t5_ack_cycle", k, 8);
      end
      if (k >= 1 && k <= 8) chk("t5_no_accept", req_ready, 0);
      tick();
    end
    req_valid = 1'b0; flush = 1'b0; b_valid = 1'b0;
    chk("t5_ack_count", acks, 1);

    // reset in the middle of a store
    aw_ready = 1'b0; w_ready = 1'b0;
    send(64'h6000, 4'h3);
    chk("t8_pending", aw_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t8_aw_dropped", aw_valid, 0);
    chk("t8_w_dropped", w_valid, 0);
    chk("t8_cnt_clear", cnt, 0);
    tick();
    rst_n = 1'b1; aw_ready = 1'b1; w_ready = 1'b1;
    tick();
    chk("t8_idle_after", aw_valid, 0);
    chk("t8_ready_after", req_ready, 1);
`ifdef CVA6_STORE_LIMIT_ERR_CNT_EN
    chk("t8_err_cnt_clear", err_cnt, 0);
`endif
    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
